rsa_job_ctrl: RTL and testbench
===============================

# rsa_job_ctrl

Job-issuing controller that drives the `mod_exp` engine. It accepts RSA jobs over a valid/ready input channel and checks each one. It pulses `md_start` to the engine, holds the engine operands stable until `mm_2_end`, then returns the result over a valid/ready output channel. It sits between the host/bus front end and `mod_exp`, and is the initiator for the engine's start/end handshake.

## Interface
- `TIMEOUT_CYCLES`, default 1024: engine watchdog limit in clock cycles; only used when `RSA_CTRL_TIMEOUT_EN` is defined.
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: job offered.
- `in_ready` output 1: job accepted when `in_valid & in_ready`.
- `in_len` input 8: modulus bit length.
- `in_base` input 32: message or base.
- `in_exp` input 32: exponent.
- `in_mod` input 32: modulus.
- `out_valid` output 1: result available.
- `out_ready` input 1: result consumed when `out_valid & out_ready`.
- `out_data` output 32: `base^exp mod mod`, or 0 on error.
- `out_err` output 1: job rejected or timed out.
- `md_start` output 1: one-cycle engine start pulse.
- `len` output 8: length operand to the engine.
- `num_a` output 32: base operand to the engine.
- `num_b` output 32: exponent operand to the engine.
- `modulus` output 32: modulus operand to the engine.
- `mm_2_out` input 32: engine result.
- `mm_2_end` input 1: engine done.

## Operation
- Input buffer: 2-entry job FIFO.
  - `in_ready = !full`.
  - Push and pop in the same cycle are both honoured, including when full, since the pop frees a slot.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop the head into the operand registers and go to CHECK.
  - CHECK: a job is invalid if `len == 0`, `len > 32`, or `mod[0] == 0` (Montgomery requires an odd modulus).
    - Invalid job: set result=0, err=1, go to DONE. No `md_start` is issued.
    - Valid job: go to START.
  - START: drive `md_start=1` for exactly this cycle, clear the watchdog, go to WAIT.
  - WAIT: on `mm_2_end=1`, latch `mm_2_out` into `out_data`, set err=0, go to DONE.
  - DONE: drive `out_valid=1` and hold `out_data`/`out_err` stable. On `out_ready`, go to IDLE.
- `mm_2_end` is ignored outside WAIT.
- Operand outputs (`len`, `num_a`, `num_b`, `modulus`) come from registers. They change only on the IDLE→CHECK load and are stable from START through WAIT.
- One job is in flight at a time. Results leave in job order.
- Reset mid-operation: every state is lost, FIFO empties, the engine is not re-pulsed. The engine itself is reset by the same `rstn`.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_data=0`, `out_err=0`, `md_start=0`.
  - `len=0`, `num_a=0`, `num_b=0`, `modulus=0`, FSM=IDLE.
- Accept to `md_start`, with IDLE and FIFO empty: job accepted at cycle 0, `md_start` high at cycle 3 (FIFO write, IDLE→CHECK, CHECK→START).
- Invalid job: accept at cycle 0, `out_valid` at cycle 3.
- `mm_2_end` sampled high at cycle N gives `out_valid` at N+1.
- `out_valid` held under backpressure for any number of cycles. The next job is not started until the result is consumed.

## Configuration
- `RSA_CTRL_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT.
  - Reaching `TIMEOUT_CYCLES` without `mm_2_end` forces DONE with `out_data=0`, `out_err=1`.
  - If `mm_2_end` and timeout occur in the same cycle, `mm_2_end` wins.
- `RSA_CTRL_TIMEOUT_EN` undefined:
  - No counter. WAIT holds indefinitely.
  - `out_err` is driven only by the CHECK rejection.

## Structure
- Shared package `rsa_pkg` holds:
  - FSM state enum (IDLE, CHECK, START, WAIT, DONE);
  - `RSA_W=32`, `RSA_LEN_W=8`;
  - job struct (len, base, exp, mod).
- Sub-module `rsa_job_fifo`: 2-entry synchronous FIFO of job structs with `full`/`empty` flags, async active-low reset.

## Test plan
The bench uses a behavioural `mod_exp` model with a fixed 40-cycle latency.
- Job len=9, base=4, exp=13, mod=497 → single `md_start` pulse 3 cycles after accept; `out_data=445`, `out_err=0`.
- Job with mod=496 → no `md_start`; `out_valid` 3 cycles after accept with `out_data=0`, `out_err=1`. Repeat with len=0 and len=33 → same response.
- Three jobs back-to-back with `out_ready=0`:
  - `in_ready` drops after the FIFO fills;
  - after `out_ready` is raised, results appear in order: (4,13,497)→445, (2,10,1000003)→1024, (3,5,7)→5.
- Stray `mm_2_end` pulse while in IDLE/DONE → ignored; `out_data` is unchanged.
- With `RSA_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, engine model never ends → `out_err=1`, `out_data=0`; the next job completes normally.
- `rstn` low during WAIT → all outputs return to reset values within the same cycle; FIFO is empty and `in_ready=1` after release.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the RSA job controller: FSM states, job record and operand widths.
package rsa_pkg;

  localparam int unsigned RSA_W     = 32;
  localparam int unsigned RSA_LEN_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StStart,
    StWait,
    StDone
  } rsa_state_e;

  typedef struct packed {
    logic [RSA_LEN_W-1:0] len;
    logic [RSA_W-1:0]     base;
    logic [RSA_W-1:0]     exp;
    logic [RSA_W-1:0]     mod;
  } rsa_job_t;

  // Montgomery reduction needs an odd modulus; length must fit the datapath.
  function automatic logic job_invalid(input rsa_job_t job);
    return (job.len == '0) || (job.len > RSA_LEN_W'(RSA_W)) || !job.mod[0];
  endfunction

endpackage

// File: rtl/rsa_job_fifo.sv
// Two-entry synchronous job FIFO; a pop frees a slot for a push in the same cycle.
module rsa_job_fifo
  import rsa_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     push_i,
  input  rsa_job_t wdata_i,
  input  logic     pop_i,
  output rsa_job_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  rsa_job_t   mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/rsa_job_ctrl.sv
// Issues buffered RSA jobs to the mod_exp engine and returns results in order.
// Define RSA_CTRL_TIMEOUT_EN to add an engine watchdog of TIMEOUT_CYCLES cycles.
module rsa_job_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RSA_LEN_W-1:0] in_len,
  input  logic [RSA_W-1:0]     in_base,
  input  logic [RSA_W-1:0]     in_exp,
  input  logic [RSA_W-1:0]     in_mod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RSA_W-1:0]     out_data,
  output logic                 out_err,
  output logic                 md_start,
  output logic [RSA_LEN_W-1:0] len,
  output logic [RSA_W-1:0]     num_a,
  output logic [RSA_W-1:0]     num_b,
  output logic [RSA_W-1:0]     modulus,
  input  logic [RSA_W-1:0]     mm_2_out,
  input  logic                 mm_2_end
);

  rsa_state_e       state_q, state_d;
  rsa_job_t         job_q, fifo_rdata, fifo_wdata;
  logic [RSA_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign fifo_wdata = '{len: in_len, base: in_base, exp: in_exp, mod: in_mod};
  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;

  rsa_job_fifo u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef RSA_CTRL_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        wd_hit;

  assign wd_hit = (wd_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q <= '0;
    end else if (state_q == StStart) begin
      wd_q <= '0;
    end else if (state_q == StWait) begin
      wd_q <= wd_q + 16'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    md_start  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (job_invalid(job_q)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          state_d = StStart;
        end
      end
      StStart: begin
        md_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        // A completion in the same cycle as the watchdog expiry takes precedence.
        if (mm_2_end) begin
          result_d = mm_2_out;
          err_d    = 1'b0;
          state_d  = StDone;
        end
`ifdef RSA_CTRL_TIMEOUT_EN
        else if (wd_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StDone;
        end
`endif
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      job_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      if (fifo_pop) begin
        job_q <= fifo_rdata;
      end
    end
  end

  assign out_data = result_q;
  assign out_err  = err_q;
  assign len      = job_q.len;
  assign num_a    = job_q.base;
  assign num_b    = job_q.exp;
  assign modulus  = job_q.mod;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Directed bench for rsa_job_ctrl with a behavioural 40-cycle mod_exp engine.
module tb_rsa_job_ctrl;
  import rsa_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_len = '0;
  logic [31:0] in_base = '0, in_exp = '0, in_mod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;
  logic        md_start;
  logic [7:0]  len;
  logic [31:0] num_a, num_b, modulus;
  logic [31:0] mm_2_out;
  logic        mm_2_end;

  int n_checks = 0;
  int n_fail   = 0;
  int md_cnt   = 0;
  int m0;

  always #5 clk = ~clk;

  rsa_job_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_len    (in_len),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .in_mod    (in_mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .md_start  (md_start),
    .len       (len),
    .num_a     (num_a),
    .num_b     (num_b),
    .modulus   (modulus),
    .mm_2_out  (mm_2_out),
    .mm_2_end  (mm_2_end)
  );

  function automatic logic [31:0] mod_exp_ref(input logic [31:0] b, input logic [31:0] e,
                                              input logic [31:0] m);
    logic [63:0] r, x, mm;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  // Engine model: updates just after the rising edge so values are settled by the falling edge.
  logic        eng_busy = 1'b0, eng_end = 1'b0, eng_hang = 1'b0, stray_end = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_res = '0;

  assign mm_2_end = eng_end | stray_end;
  assign mm_2_out = eng_res;

  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      eng_busy = 1'b0;
      eng_end  = 1'b0;
      eng_cnt  = 0;
    end else begin
      eng_end = 1'b0;
      if (md_start && !eng_hang) begin
        eng_busy = 1'b1;
        eng_cnt  = 40;
        eng_res  = mod_exp_ref(num_a, num_b, modulus);
      end else if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_end  = 1'b1;
          eng_busy = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) if (md_start) md_cnt <= md_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] l, input logic [31:0] b, input logic [31:0] e,
                      input logic [31:0] m);
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_len   = l;
    in_base  = b;
    in_exp   = e;
    in_mod   = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int max, input string tag);
    for (int i = 0; i < max && !out_valid; i++) tick();
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_end(input int max, input string tag);
    for (int i = 0; i < max && !mm_2_end; i++) tick();
    check(tag, {31'd0, mm_2_end}, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    check({tag, "_md_start"}, {31'd0, md_start}, 32'd0);
    check({tag, "_len"}, {24'd0, len}, 32'd0);
    check({tag, "_num_a"}, num_a, 32'd0);
    check({tag, "_num_b"}, num_b, 32'd0);
    check({tag, "_modulus"}, modulus, 32'd0);
  endtask

  logic [7:0]  bad_len [3] = '{8'd9, 8'd0, 8'd33};
  logic [31:0] bad_mod [3] = '{32'd496, 32'd497, 32'd497};
  logic [7:0]  b2b_len [3] = '{8'd9, 8'd20, 8'd3};
  logic [31:0] b2b_b   [3] = '{32'd4, 32'd2, 32'd3};
  logic [31:0] b2b_e   [3] = '{32'd13, 32'd10, 32'd5};
  logic [31:0] b2b_m   [3] = '{32'd497, 32'd1000003, 32'd7};
  logic [31:0] b2b_r   [3] = '{32'd445, 32'd1024, 32'd5};

  initial begin
    repeat (2) tick();
    check_reset_values("rst");
    rstn = 1'b1;
    tick();

    // Single valid job: start pulse timing, operands, completion latency, backpressure.
    m0 = md_cnt;
    send(8'd9, 32'd4, 32'd13, 32'd497);
    check("a_md_c1", {31'd0, md_start}, 32'd0);
    tick();
    check("a_md_c2", {31'd0, md_start}, 32'd0);
    tick();
    check("a_md_c3", {31'd0, md_start}, 32'd1);
    check("a_len", {24'd0, len}, 32'd9);
    check("a_num_a", num_a, 32'd4);
    check("a_num_b", num_b, 32'd13);
    check("a_modulus", modulus, 32'd497);
    tick();
    check("a_md_c4", {31'd0, md_start}, 32'd0);
    wait_end(100, "a_end_seen");
    check("a_ov_at_end", {31'd0, out_valid}, 32'd0);
    check("a_ops_stable", modulus, 32'd497);
    tick();
    check("a_ov_next", {31'd0, out_valid}, 32'd1);
    check("a_data", out_data, 32'd445);
    check("a_err", {31'd0, out_err}, 32'd0);
    repeat (5) tick();
    check("a_hold_ov", {31'd0, out_valid}, 32'd1);
    check("a_hold_data", out_data, 32'd445);
    stray_end = 1'b1;
    tick();
    stray_end = 1'b0;
    tick();
    check("stray_done_data", out_data, 32'd445);
    check("stray_done_ov", {31'd0, out_valid}, 32'd1);
    check("a_md_count", 32'(md_cnt - m0), 32'd1);
    consume();
    check("a_consumed", {31'd0, out_valid}, 32'd0);
    stray_end = 1'b1;
    tick();
    stray_end = 1'b0;
    tick();
    check("stray_idle_data", out_data, 32'd445);
    check("stray_idle_ov", {31'd0, out_valid}, 32'd0);
    check("stray_idle_md", 32'(md_cnt - m0), 32'd1);

    // Rejected jobs: even modulus, zero length, oversize length.
    for (int i = 0; i < 3; i++) begin
      m0 = md_cnt;
      send(bad_len[i], 32'd4, 32'd13, bad_mod[i]);
      check($sformatf("bad%0d_ov_c1", i), {31'd0, out_valid}, 32'd0);
      tick();
      check($sformatf("bad%0d_ov_c2", i), {31'd0, out_valid}, 32'd0);
      tick();
      check($sformatf("bad%0d_ov_c3", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bad%0d_data", i), out_data, 32'd0);
      check($sformatf("bad%0d_err", i), {31'd0, out_err}, 32'd1);
      consume();
      check($sformatf("bad%0d_no_md", i), 32'(md_cnt - m0), 32'd0);
    end

    // Three jobs back-to-back under result backpressure.
    m0 = md_cnt;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_rdy%0d", i), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_len   = b2b_len[i];
      in_base  = b2b_b[i];
      in_exp   = b2b_e[i];
      in_mod   = b2b_m[i];
      tick();
    end
    in_valid = 1'b0;
    check("b2b_full", {31'd0, in_ready}, 32'd0);
    wait_ov(200, "b2b_first_ov");
    repeat (10) tick();
    check("b2b_hold_ov", {31'd0, out_valid}, 32'd1);
    check("b2b_hold_rdy", {31'd0, in_ready}, 32'd0);
    check("b2b_one_start", 32'(md_cnt - m0), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ov(200, $sformatf("b2b_ov%0d", i));
      check($sformatf("b2b_data%0d", i), out_data, b2b_r[i]);
      check($sformatf("b2b_err%0d", i), {31'd0, out_err}, 32'd0);
      tick();
    end
    out_ready = 1'b0;
    check("b2b_drained", {31'd0, in_ready}, 32'd1);

`ifdef RSA_CTRL_TIMEOUT_EN
    eng_hang = 1'b1;
    send(8'd9, 32'd4, 32'd13, 32'd497);
    wait_ov(60, "to_ov");
    check("to_data", out_data, 32'd0);
    check("to_err", {31'd0, out_err}, 32'd1);
    consume();
    eng_hang = 1'b0;
    send(8'd3, 32'd3, 32'd5, 32'd7);
    wait_ov(100, "to_next_ov");
    check("to_next_data", out_data, 32'd5);
    check("to_next_err", {31'd0, out_err}, 32'd0);
    consume();
`else
    eng_hang = 1'b1;
    send(8'd9, 32'd4, 32'd13, 32'd497);
    repeat (100) tick();
    check("hang_no_ov", {31'd0, out_valid}, 32'd0);
    eng_hang = 1'b0;
`endif

    // Reset while a job is waiting on the engine with more queued behind it.
    send(8'd9, 32'd4, 32'd13, 32'd497);
    send(8'd3, 32'd3, 32'd5, 32'd7);
    repeat (10) tick();
    check("pre_rst_len", {24'd0, len}, 32'd9);
    rstn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    tick();
    rstn = 1'b1;
    m0 = md_cnt;
    repeat (10) tick();
    check("post_rst_no_md", 32'(md_cnt - m0), 32'd0);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    check("post_rst_ov", {31'd0, out_valid}, 32'd0);
    send(8'd3, 32'd3, 32'd5, 32'd7);
    wait_ov(100, "post_rst_job_ov");
    check("post_rst_job_data", out_data, 32'd5);
    check("post_rst_job_err", {31'd0, out_err}, 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
